cmd_dispatch_ctrl: RTL and testbench
====================================

CMD_DISPATCH_CTRL -- requirements
Module: cmd_dispatch_ctrl

Interface
REQ-001 SHALL have parameter MAP_MASK, default 8'b1110_1111, bit i=1 marks opcode i as mapped to handler unit i (opcode 4 unmapped by default).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles spent in WAIT before abort (legal range 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, width of the statistics counters.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  opcode offered.
REQ-007 cmd_code  input  3  opcode value 0..7.
REQ-008 cmd_ready  output  1  controller accepts opcode this cycle.
REQ-009 unit_start  output  8  one-hot start pulse to handler unit i.
REQ-010 unit_done  input  8  per-unit completion pulse.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_code  output  3  opcode the response belongs to.
REQ-014 rsp_status  output  2  00 OK, 01 DEFAULT (unmapped), 10 TIMEOUT; 11 never driven.
REQ-015 default_cnt  output  CNT_W  count of unmapped opcodes taken.
REQ-016 timeout_cnt  output  CNT_W  count of handler timeouts.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, DISPATCH, WAIT, RESP.
REQ-019 IDLE: cmd_ready=1; handshake = cmd_valid&cmd_ready; on handshake latch cmd_code into code register.
REQ-020 IDLE handshake with MAP_MASK[cmd_code]=1 -> DISPATCH; with MAP_MASK[cmd_code]=0 -> RESP, status DEFAULT, default_cnt+1.
REQ-021 DISPATCH: unit_start[code]=1 for exactly one cycle, timer cleared to 0, -> WAIT.
REQ-022 unit_start SHALL be all-zero outside DISPATCH and never have more than one bit set.
REQ-023 WAIT: sample only unit_done[code]; done=1 -> RESP, status OK; done bits of other units ignored.
REQ-024 WAIT: timer increments each cycle without done; cycle where timer==TIMEOUT-1 and no done -> RESP, status TIMEOUT, timeout_cnt+1.
REQ-025 WAIT: done and timeout in same cycle -> OK wins, timeout_cnt unchanged.
REQ-026 unit_done in DISPATCH cycle SHALL be ignored (handler done earliest one cycle after start).
REQ-027 RESP: rsp_valid=1, rsp_code/rsp_status stable until rsp_valid&rsp_ready; then -> IDLE.
REQ-028 cmd_ready SHALL be 0 in DISPATCH, WAIT, RESP; no new opcode accepted until response consumed.
REQ-029 Latency: handshake cycle N; mapped -> unit_start at N+1, done sampled at M -> rsp_valid at M+1; unmapped -> rsp_valid at N+1.
REQ-030 Counters saturate at all-ones; no wrap.
REQ-031 Opcodes 0..7 fully covered; no state decodes to X; unreachable state encodings return to IDLE next cycle.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE, timer=0, code=0, default_cnt=0, timeout_cnt=0.
REQ-033 During/after reset outputs: cmd_ready=1 (post reset), unit_start=0, rsp_valid=0, rsp_code=0, rsp_status=00, busy=0.
REQ-034 Reset mid-operation (DISPATCH/WAIT/RESP) SHALL abandon the command without response; later unit_done pulses are ignored in IDLE.

Verification
REQ-035 Mapped: cmd_code=3 accepted cycle N, unit_done[3] at N+4 -> unit_start=8'h08 at N+1 only, rsp_valid at N+5, rsp_code=3, status 00.
REQ-036 Unmapped: cmd_code=4 accepted cycle N -> unit_start stays 0, rsp_valid at N+1, rsp_code=4, status 01, default_cnt 0->1.
REQ-037 Timeout: cmd_code=7, no done, TIMEOUT=15 -> rsp at 15 cycles after WAIT entry with status 10, timeout_cnt=1; stray unit_done[2] during WAIT has no effect.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/code/status held, cmd_ready=0, second cmd_valid not accepted until one cycle after response handshake.
REQ-039 Saturation: 260 unmapped commands with CNT_W=8 -> default_cnt=255.
REQ-040 Reset in WAIT with cmd_code=1 -> next cycle IDLE, busy=0, no rsp_valid, counters 0, late unit_done[1] ignored.

Source files
------------

// File: rtl/cmd_dispatch_ctrl.sv
// Opcode dispatcher: hands each accepted opcode to its handler unit, waits for
// completion or a timeout, and returns a single status response per command.
module cmd_dispatch_ctrl #(
    parameter logic [7:0]  MAP_MASK = 8'b1110_1111,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_code,
    output logic             cmd_ready,
    output logic [7:0]       unit_start,
    input  logic [7:0]       unit_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_code,
    output logic [1:0]       rsp_status,
    output logic [CNT_W-1:0] default_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             busy
);

    // state    | meaning
    // IDLE     | ready for a new opcode
    // DISPATCH | one-cycle start pulse to the selected handler
    // WAIT     | waiting for that handler's done, timer running
    // RESP     | response held until consumed
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_DEFAULT = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [7:0] TMO_LAST     = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       timer_q, timer_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] default_cnt_q, default_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            code_q        <= 3'd0;
            timer_q       <= 8'd0;
            status_q      <= STAT_OK;
            default_cnt_q <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            timer_q       <= timer_d;
            status_q      <= status_d;
            default_cnt_q <= default_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        timer_d       = timer_q;
        status_d      = status_q;
        default_cnt_d = default_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    code_d = cmd_code;
                    if (MAP_MASK[cmd_code]) begin
                        state_d = ST_DISPATCH;
                    end else begin
                        state_d  = ST_RESP;
                        status_d = STAT_DEFAULT;
                        if (default_cnt_q != CNT_MAX)
                            default_cnt_d = default_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DISPATCH: begin
                timer_d = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (unit_done[code_q]) begin
                    state_d  = ST_RESP;
                    status_d = STAT_OK;
                end else if (timer_q == TMO_LAST) begin
                    state_d  = ST_RESP;
                    status_d = STAT_TIMEOUT;
                    if (timeout_cnt_q != CNT_MAX)
                        timeout_cnt_d = timeout_cnt_q + CNT_ONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign unit_start  = (state_q == ST_DISPATCH) ? (8'b1 << code_q) : 8'b0;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_code    = rsp_valid ? code_q : 3'd0;
    assign rsp_status  = rsp_valid ? status_q : STAT_OK;
    assign default_cnt = default_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_cmd_dispatch_ctrl.sv
// Bench for cmd_dispatch_ctrl: directed scenarios plus randomized commands,
// compared against a transaction-level latency/status model.
module tb_cmd_dispatch_ctrl;

    localparam logic [7:0] MASK    = 8'b1110_1111;
    localparam int         TMO     = 15;
    localparam int         CNT_MAX = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic [7:0] unit_start;
    logic [7:0] unit_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_code;
    logic [1:0] rsp_status;
    logic [7:0] default_cnt;
    logic [7:0] timeout_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int def_m  = 0;
    int to_m   = 0;

    cmd_dispatch_ctrl #(.MAP_MASK(MASK), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .unit_start(unit_start), .unit_done(unit_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
        .rsp_status(rsp_status), .default_cnt(default_cnt),
        .timeout_cnt(timeout_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // done_off: edge (counted from the accept edge) at which unit_done[c] is
    // pulsed, 0 for never. Handler done is legal from edge 2 through TMO+1.
    task automatic run_cmd(input logic [2:0] c, input int done_off,
                           input logic [7:0] stray, input int hold);
        logic [7:0] onehot;
        logic [1:0] st;
        int         lat;
        onehot = 8'h01 << c;
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_code  = c;
        step();
        cmd_valid = 1'b0;
        cmd_code  = 3'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("ready_low_after_accept", cmd_ready, 0);
        if (!MASK[c]) begin
            lat   = 0;
            st    = 2'b01;
            def_m = sat(def_m + 1);
            chk("unmapped_no_start", unit_start, 0);
        end else begin
            if (done_off >= 2 && done_off <= TMO + 1) begin
                lat = done_off;
                st  = 2'b00;
            end else begin
                lat  = TMO + 1;
                st   = 2'b10;
                to_m = sat(to_m + 1);
            end
            chk("start_onehot", unit_start, onehot);
            chk("no_rsp_in_dispatch", rsp_valid, 0);
            for (int k = 1; k <= lat; k++) begin
                unit_done = stray & ~onehot;
                if (k == done_off) unit_done = unit_done | onehot;
                step();
                unit_done = 8'h00;
                chk("start_single_cycle", unit_start, 0);
                chk("rsp_latency", rsp_valid, (k == lat));
            end
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_code", rsp_code, c);
        chk("rsp_status", rsp_status, st);
        chk("default_cnt", default_cnt, def_m);
        chk("timeout_cnt", timeout_cnt, to_m);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_code  = 3'($urandom);
            unit_done = 8'($urandom);
            step();
            unit_done = 8'h00;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_code", rsp_code, c);
            chk("hold_status", rsp_status, st);
            chk("hold_no_accept", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_dropped", rsp_valid, 0);
        chk("idle_after_rsp", busy, 0);
        chk("ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 3'd0;
        unit_done = 8'h00;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_start", unit_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_code", rsp_code, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_default_cnt", default_cnt, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", cmd_ready, 1);

        run_cmd(3'd3, 4, 8'h00, 0);           // mapped, done at N+4
        run_cmd(3'd4, 0, 8'h00, 0);           // unmapped, default count 0->1
        run_cmd(3'd7, 0, 8'h04, 0);           // timeout with stray done on unit 2
        run_cmd(3'd2, 3, 8'h00, 5);           // backpressure
        run_cmd(3'd5, 1, 8'h00, 0);           // done in dispatch cycle is ignored
        run_cmd(3'd6, TMO + 1, 8'h00, 0);     // done on the timeout cycle wins
        run_cmd(3'd1, TMO + 2, 8'h00, 1);     // done one cycle too late
        run_cmd(3'd0, 2, 8'hff, 0);           // earliest done, all strays set

        for (int i = 0; i < 60; i++)
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
                    8'($urandom), int'($urandom_range(0, 3)));

        // Reset while waiting on unit 1 abandons the command.
        cmd_valid = 1'b1;
        cmd_code  = 3'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        def_m = 0;
        to_m  = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_default_cnt", default_cnt, 0);
        chk("midrst_timeout_cnt", timeout_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            unit_done = 8'h02;
            step();
            unit_done = 8'h00;
            chk("late_done_busy", busy, 0);
            chk("late_done_rsp", rsp_valid, 0);
        end

        for (int i = 0; i < 260; i++)
            run_cmd(3'd4, 0, 8'h00, 0);
        chk("default_saturated", default_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
